pkt_tx_serializer: RTL and testbench

- Downstream stage of the reward block. Captures the eight packed reward words on each reward_done strobe and queues them in a small packet buffer.
- Serializes each queued packet, one 16-bit word per handshake, onto the radio/MAC TX word stream (valid/ready).
- Enforces a programmable inter-packet gap and reports drops when the buffer overflows.

---
 rtl/pkt_tx_serializer_pkg.sv | 62 ++++++
 rtl/pkt_tx_serializer_if.sv | 15 +
 rtl/pkt_tx_serializer_fifo.sv | 58 +++++
 rtl/pkt_tx_serializer.sv | 149 ++++++++++++++
 tb/tb_pkt_tx_serializer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_tx_serializer_pkg.sv
// Shared types for the reward-packet TX path.
// TX_CHECKSUM_EN appends an XOR checksum word (PKT_WORDS 8 -> 9).
package eer_pkg;

    localparam int WORD_WIDTH = 16;

`ifdef TX_CHECKSUM_EN
    localparam int PKT_WORDS = 9;
    localparam int PKT_IDX_W = 4;
`else
    localparam int PKT_WORDS = 8;
    localparam int PKT_IDX_W = 3;
`endif

    localparam logic [2:0] PT_HB  = 3'b000;
    localparam logic [2:0] PT_ADV = 3'b001;
    localparam logic [2:0] PT_INV = 3'b010;
    localparam logic [2:0] PT_ACK = 3'b011;
    localparam logic [2:0] PT_DAT = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } tx_state_t;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] packet_type;
        logic [WORD_WIDTH-1:0] source_id;
        logic [WORD_WIDTH-1:0] destination_id;
        logic [WORD_WIDTH-1:0] source_hops;
        logic [WORD_WIDTH-1:0] energy_left;
        logic [WORD_WIDTH-1:0] q_value;
        logic [WORD_WIDTH-1:0] chosen_ch;
        logic [WORD_WIDTH-1:0] hops_from_ch;
`ifdef TX_CHECKSUM_EN
        logic [WORD_WIDTH-1:0] checksum;
`endif
    } pkt_t;

    // Wire-order word selector: index 0 is the packet type.
    function automatic logic [WORD_WIDTH-1:0] pkt_word(pkt_t p, logic [PKT_IDX_W-1:0] idx);
        logic [WORD_WIDTH-1:0] w;
        w = '0;
        case (int'(idx))
            0: w = p.packet_type;
            1: w = p.source_id;
            2: w = p.destination_id;
            3: w = p.source_hops;
            4: w = p.energy_left;
            5: w = p.q_value;
            6: w = p.chosen_ch;
            7: w = p.hops_from_ch;
`ifdef TX_CHECKSUM_EN
            8: w = p.checksum;
`endif
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/pkt_tx_serializer_if.sv
// TX word-stream handshake bundle between the serializer and the MAC.
interface pkt_tx_serializer_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  tx_valid;
    logic                  tx_ready;
    logic [WORD_WIDTH-1:0] tx_data;
    logic                  tx_sop;
    logic                  tx_eop;

    modport master (output tx_valid, output tx_data, output tx_sop, output tx_eop,
                    input  tx_ready);
    modport slave  (input  tx_valid, input  tx_data, input  tx_sop, input  tx_eop,
                    output tx_ready);
endinterface

// File: rtl/pkt_tx_serializer_fifo.sv
// Whole-packet FIFO; a push while full is accepted only alongside a pop.
module pkt_fifo
    import eer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic push,
    input  logic pop,
    input  pkt_t din,
    output pkt_t dout,
    output logic full,
    output logic empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    pkt_t          mem [DEPTH];
    logic [AW-1:0] wr_idx, rd_idx;
    logic          wr_wrap, rd_wrap;
    logic          do_push, do_pop;

    assign empty   = (wr_idx == rd_idx) && (wr_wrap == rd_wrap);
    assign full    = (wr_idx == rd_idx) && (wr_wrap != rd_wrap);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx  <= '0;
            rd_idx  <= '0;
            wr_wrap <= 1'b0;
            rd_wrap <= 1'b0;
        end else if (clear) begin
            wr_idx  <= '0;
            rd_idx  <= '0;
            wr_wrap <= 1'b0;
            rd_wrap <= 1'b0;
        end else begin
            if (do_push) begin
                wr_idx <= (wr_idx == LAST) ? '0 : wr_idx + 1'b1;
                if (wr_idx == LAST) wr_wrap <= ~wr_wrap;
            end
            if (do_pop) begin
                rd_idx <= (rd_idx == LAST) ? '0 : rd_idx + 1'b1;
                if (rd_idx == LAST) rd_wrap <= ~rd_wrap;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_idx] <= din;
    end

endmodule

// File: rtl/pkt_tx_serializer.sv
// Buffers reward packets and serializes them word by word with an inter-packet gap.
// Build option: TX_CHECKSUM_EN adds a trailing XOR checksum word.
module pkt_tx_serializer
    import eer_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int PKT_DEPTH  = 2,
    parameter int IFG_CYCLES = 2,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reward_done,
    input  logic [WORD_WIDTH-1:0] rPacketType,
    input  logic [WORD_WIDTH-1:0] rSourceID,
    input  logic [WORD_WIDTH-1:0] rDestinationID,
    input  logic [WORD_WIDTH-1:0] rSourceHops,
    input  logic [WORD_WIDTH-1:0] rEnergyLeft,
    input  logic [WORD_WIDTH-1:0] rQValue,
    input  logic [WORD_WIDTH-1:0] rChosenCH,
    input  logic [WORD_WIDTH-1:0] rHopsFromCH,
    input  logic                  flush,
    pkt_tx_serializer_if.master   tx,
    output logic                  tx_pkt_done,
    output logic                  busy,
    output logic [DROP_CNT_W-1:0] drop_count
);
    localparam logic [PKT_IDX_W-1:0] LAST_IDX = PKT_IDX_W'(PKT_WORDS - 1);
    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_CYCLES - 1);

    tx_state_t             state;
    logic [PKT_IDX_W-1:0]  word_idx;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  tx_valid_q, tx_sop_q, tx_eop_q, pkt_done_q;
    logic [WORD_WIDTH-1:0] tx_data_q;
    logic [DROP_CNT_W-1:0] drop_q;

    pkt_t in_pkt, head, launch_pkt;
    logic fifo_full, fifo_empty;
    logic push, pop, push_acc, drop, start_now;

    always_comb begin
        in_pkt                = '0;
        in_pkt.packet_type    = rPacketType;
        in_pkt.source_id      = rSourceID;
        in_pkt.destination_id = rDestinationID;
        in_pkt.source_hops    = rSourceHops;
        in_pkt.energy_left    = rEnergyLeft;
        in_pkt.q_value        = rQValue;
        in_pkt.chosen_ch      = rChosenCH;
        in_pkt.hops_from_ch   = rHopsFromCH;
`ifdef TX_CHECKSUM_EN
        in_pkt.checksum = rPacketType ^ rSourceID ^ rDestinationID ^ rSourceHops ^
                          rEnergyLeft ^ rQValue ^ rChosenCH ^ rHopsFromCH;
`endif
    end

    assign push     = reward_done && !flush;
    assign pop      = tx_valid_q && tx.tx_ready && tx_eop_q && !flush;
    assign push_acc = push && (!fifo_full || pop);
    assign drop     = push && !push_acc;

    // An empty buffer launches straight from the capture inputs to meet one-cycle latency.
    assign launch_pkt = fifo_empty ? in_pkt : head;
    assign start_now  = !flush && (!fifo_empty || push_acc) &&
                        ((state == S_IDLE) || ((state == S_GAP) && (gap_cnt == GAP_LAST)));

    pkt_fifo #(.DEPTH(PKT_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .din   (in_pkt),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            word_idx   <= '0;
            gap_cnt    <= '0;
            tx_valid_q <= 1'b0;
            tx_sop_q   <= 1'b0;
            tx_eop_q   <= 1'b0;
            tx_data_q  <= '0;
            pkt_done_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            pkt_done_q <= 1'b0;
            if (drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;

            if (flush) begin
                state      <= S_IDLE;
                word_idx   <= '0;
                gap_cnt    <= '0;
                tx_valid_q <= 1'b0;
                tx_sop_q   <= 1'b0;
                tx_eop_q   <= 1'b0;
            end else if (start_now) begin
                state      <= S_SEND;
                word_idx   <= '0;
                tx_valid_q <= 1'b1;
                tx_sop_q   <= 1'b1;
                tx_eop_q   <= (LAST_IDX == '0);
                tx_data_q  <= pkt_word(launch_pkt, '0);
            end else begin
                unique case (state)
                    S_IDLE: ;
                    S_SEND: begin
                        if (tx.tx_ready) begin
                            if (word_idx == LAST_IDX) begin
                                pkt_done_q <= 1'b1;
                                tx_valid_q <= 1'b0;
                                tx_sop_q   <= 1'b0;
                                tx_eop_q   <= 1'b0;
                                word_idx   <= '0;
                                gap_cnt    <= '0;
                                state      <= (IFG_CYCLES > 0) ? S_GAP : S_IDLE;
                            end else begin
                                word_idx  <= word_idx + 1'b1;
                                tx_data_q <= pkt_word(head, word_idx + 1'b1);
                                tx_sop_q  <= 1'b0;
                                tx_eop_q  <= ((word_idx + 1'b1) == LAST_IDX);
                            end
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == GAP_LAST) state <= S_IDLE;
                        else gap_cnt <= gap_cnt + 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_data  = tx_data_q;
    assign tx.tx_sop   = tx_sop_q;
    assign tx.tx_eop   = tx_eop_q;
    assign tx_pkt_done = pkt_done_q;
    assign drop_count  = drop_q;
    assign busy        = !fifo_empty || (state != S_IDLE);

endmodule

// File: tb/tb_pkt_tx_serializer.sv
// Directed + randomized bench for pkt_tx_serializer against a packet-queue model.
module tb_pkt_tx_serializer;
    import eer_pkg::*;

    localparam int WW    = 16;
    localparam int DEPTH = 2;
    localparam int IFG   = 2;
    localparam int DW    = 8;
    localparam int NW    = PKT_WORDS;
    localparam int DMAX  = (1 << DW) - 1;

    typedef logic [NW-1:0][WW-1:0] pw_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          reward_done = 1'b0;
    logic          flush = 1'b0;
    logic [WW-1:0] rw [8];
    logic          tx_pkt_done, busy;
    logic [DW-1:0] drop_count;

    pkt_tx_serializer_if #(.WORD_WIDTH(WW)) tx_if ();

    pkt_tx_serializer #(
        .WORD_WIDTH (WW),
        .PKT_DEPTH  (DEPTH),
        .IFG_CYCLES (IFG),
        .DROP_CNT_W (DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .reward_done    (reward_done),
        .rPacketType    (rw[0]),
        .rSourceID      (rw[1]),
        .rDestinationID (rw[2]),
        .rSourceHops    (rw[3]),
        .rEnergyLeft    (rw[4]),
        .rQValue        (rw[5]),
        .rChosenCH      (rw[6]),
        .rHopsFromCH    (rw[7]),
        .flush          (flush),
        .tx             (tx_if),
        .tx_pkt_done    (tx_pkt_done),
        .busy           (busy),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    pw_t q[$];
    int pos = 0, exp_drop = 0, cyc = 0;
    bit exp_done = 0, hold_prev = 0;
    logic [WW-1:0] hold_data;
    logic hold_sop, hold_eop;
    int eop_cyc, sop_cyc, c0, n;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic pw_t make_pkt();
        pw_t p;
        logic [WW-1:0] x;
        p = '0;
        x = '0;
        for (int k = 0; k < 8; k++) begin
            p[k] = rw[k];
            x ^= rw[k];
        end
`ifdef TX_CHECKSUM_EN
        p[8] = x;
`endif
        return p;
    endfunction

    task automatic set_test_words();
        rw[0] = 16'h0000; rw[1] = 16'h0005; rw[2] = 16'h0001; rw[3] = 16'h0003;
        rw[4] = 16'h0064; rw[5] = 16'h0010; rw[6] = 16'h0002; rw[7] = 16'h0001;
    endtask

    task automatic rand_words();
        for (int k = 0; k < 8; k++) rw[k] = 16'($urandom);
    endtask

    // One clock: check the visible cycle against the model, apply its rules, advance.
    task automatic tick();
        bit hs, eop_hs;
        pw_t h;
        hs = tx_if.tx_valid && tx_if.tx_ready;
        eop_hs = 0;
        chk("pkt_done", tx_pkt_done, exp_done);
        exp_done = 0;
        if (hold_prev) begin
            chk("hold_valid", tx_if.tx_valid, 1'b1);
            chk("hold_data", tx_if.tx_data, hold_data);
            chk("hold_sop", tx_if.tx_sop, hold_sop);
            chk("hold_eop", tx_if.tx_eop, hold_eop);
        end
        if (tx_if.tx_valid) begin
            if (q.size() == 0) begin
                chk("valid_without_pkt", tx_if.tx_valid, 1'b0);
            end else begin
                h = q[0];
                chk("data", tx_if.tx_data, h[pos]);
                chk("sop", tx_if.tx_sop, pos == 0);
                chk("eop", tx_if.tx_eop, pos == NW - 1);
                eop_hs = hs && (pos == NW - 1);
                if (tx_if.tx_sop) sop_cyc = cyc;
            end
        end
        if (eop_hs) eop_cyc = cyc;
        hold_prev = tx_if.tx_valid && !tx_if.tx_ready && !flush;
        hold_data = tx_if.tx_data;
        hold_sop  = tx_if.tx_sop;
        hold_eop  = tx_if.tx_eop;
        if (flush) begin
            q.delete();
            pos = 0;
        end else begin
            if (eop_hs) begin
                void'(q.pop_front());
                pos = 0;
                exp_done = 1;
            end else if (hs) begin
                pos++;
            end
            if (reward_done) begin
                if (q.size() < DEPTH) q.push_back(make_pkt());
                else if (exp_drop < DMAX) exp_drop++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("drop_count", drop_count, exp_drop);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_valid"}, tx_if.tx_valid, 1'b0);
        chk({tag, "_sop"}, tx_if.tx_sop, 1'b0);
        chk({tag, "_eop"}, tx_if.tx_eop, 1'b0);
        chk({tag, "_data"}, tx_if.tx_data, 16'h0000);
        chk({tag, "_done"}, tx_pkt_done, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_drop"}, drop_count, 8'h00);
    endtask

    task automatic apply_reset(string tag);
        rst = 1'b1;
        reward_done = 1'b0;
        flush = 1'b0;
        tx_if.tx_ready = 1'b0;
        q.delete();
        pos = 0;
        exp_done = 0;
        exp_drop = 0;
        hold_prev = 0;
        #1;
        chk_zero(tag);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_until_idle(string tag);
        int k;
        k = 0;
        while ((busy || q.size() != 0) && k < 200) begin
            tick();
            k++;
        end
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        tx_if.tx_ready = 1'b0;
        for (int k = 0; k < 8; k++) rw[k] = '0;
        @(negedge clk);
        apply_reset("reset");

        // Single packet: latency and done pulse timing.
        set_test_words();
        tx_if.tx_ready = 1'b1;
        reward_done = 1'b1;
        c0 = cyc;
        tick();
        reward_done = 1'b0;
        chk("lat_valid", tx_if.tx_valid, 1'b1);
        chk("lat_sop", tx_if.tx_sop, 1'b1);
        chk("lat_busy", busy, 1'b1);
        n = 0;
        while (!tx_pkt_done && n < 40) begin tick(); n++; end
        chk("done_latency", cyc - c0, NW + 1);
        run_until_idle("single");

        // Backpressure at word 4.
        set_test_words();
        reward_done = 1'b1;
        tick();
        reward_done = 1'b0;
        n = 0;
        while (!(tx_if.tx_valid && pos == 4) && n < 20) begin tick(); n++; end
        tx_if.tx_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_valid", tx_if.tx_valid, 1'b1);
            chk("bp_data", tx_if.tx_data, 16'h0064);
        end
        tx_if.tx_ready = 1'b1;
        run_until_idle("bp");

        // Two queued packets: inter-packet gap.
        tx_if.tx_ready = 1'b0;
        rand_words(); reward_done = 1'b1; tick();
        rand_words(); tick();
        reward_done = 1'b0;
        tx_if.tx_ready = 1'b1;
        eop_cyc = -1; sop_cyc = -1; n = 0;
        while (!(eop_cyc >= 0 && sop_cyc > eop_cyc) && n < 60) begin tick(); n++; end
        chk("ifg_gap", sop_cyc - eop_cyc, (IFG == 0) ? 2 : IFG + 1);
        run_until_idle("gap");

        // Overflow: third strobe while full is dropped.
        tx_if.tx_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_words(); reward_done = 1'b1; tick();
        end
        reward_done = 1'b0;
        chk("drop_one", drop_count, 8'd1);

        // Full buffer with eop handshake coinciding with a strobe: accepted.
        tx_if.tx_ready = 1'b1;
        n = 0;
        while (!(tx_if.tx_valid && tx_if.tx_eop) && n < 30) begin tick(); n++; end
        chk("full_eop_ready", tx_if.tx_eop, 1'b1);
        rand_words(); reward_done = 1'b1; tick();
        reward_done = 1'b0;
        chk("full_eop_drop", drop_count, 8'd1);

        // Saturation while full.
        tx_if.tx_ready = 1'b0;
        for (int k = 0; k < 300; k++) begin
            rand_words(); reward_done = 1'b1; tick();
        end
        reward_done = 1'b0;
        chk("drop_sat", drop_count, 8'hFF);
        tx_if.tx_ready = 1'b1;
        run_until_idle("sat");

        // Flush at word 3, with a competing strobe.
        set_test_words();
        reward_done = 1'b1; tick();
        reward_done = 1'b0;
        n = 0;
        while (!(tx_if.tx_valid && pos == 3) && n < 20) begin tick(); n++; end
        flush = 1'b1; reward_done = 1'b1;
        tick();
        flush = 1'b0; reward_done = 1'b0;
        chk("flush_valid", tx_if.tx_valid, 1'b0);
        chk("flush_busy", busy, 1'b0);
        tick();
        chk("flush_no_done", tx_pkt_done, 1'b0);
        chk("flush_drop", drop_count, 8'hFF);

        // Reset mid-packet: outputs clear immediately.
        rand_words(); reward_done = 1'b1; tick();
        reward_done = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        #2;
        apply_reset("midrst");

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            rand_words();
            reward_done    = ($urandom_range(0, 5) == 0);
            tx_if.tx_ready = ($urandom_range(0, 9) < 7);
            flush          = ($urandom_range(0, 99) == 0);
            tick();
        end
        reward_done = 1'b0;
        flush = 1'b0;
        tx_if.tx_ready = 1'b1;
        run_until_idle("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
